ddr_port_arbiter: RTL and testbench
===================================

Name: ddr_port_arbiter

Overview:
- Shares the single 32-bit LPDDR user port (p0 command, write and read FIFOs of the memory controller core) between two word-access requesters.
- Typical requesters: requester 0 is the image-processing pipeline, requester 1 is the host/debug interface.
- Arbitrates round-robin and sequences each access as one single-word command (burst length 1).
- Returns read data and a one-cycle ack to the winning requester; sits between the requesters and the controller core.

Parameters:
- RD_TIMEOUT, 255: cycles to wait in RD_WAIT for read data before aborting with error.
- ADDR_W, 18: width of the requester word address.

Ports:
- clk  in  1  system clock; the controller core port clocks are tied to this clock.
- rst_n  in  1  synchronous reset, active low.
- calib_done  in  1  controller calibration complete; no grant while low.
- req0, req1  in  1  request, held high until the matching ack.
- wren0, wren1  in  1  1 = write, 0 = read; held stable with req.
- addr0, addr1  in  ADDR_W  word address; held stable with req.
- wdata0, wdata1  in  32  write data; held stable with req.
- ack0, ack1  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = read timeout.
- rdata  out  32  read word; valid from ack until the next ack.
- busy  out  1  high in every state except IDLE.
- cmd_en  out  1  command FIFO push.
- cmd_instr  out  3  0 = write, 1 = read.
- cmd_bl  out  6  constant 0 (one word).
- cmd_byte_addr  out  30  {zeros, addr, 2'b00}.
- cmd_full  in  1  command FIFO full.
- wr_en  out  1  write FIFO push.
- wr_data  out  32  write word.
- wr_mask  out  4  constant 0.
- wr_full  in  1  write FIFO full.
- rd_en  out  1  read FIFO pop.
- rd_data  in  32  read FIFO head (first-word-fall-through).
- rd_empty  in  1  read FIFO empty.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - ack0, ack1, err, cmd_en, wr_en, rd_en and busy are 0; rdata is 0.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - Reset mid-operation abandons the access with no ack; FIFO contents are the core's concern.
- Strobes: all outputs are registered. cmd_en, wr_en and rd_en are single-cycle pulses.
- IDLE:
  - Stay in IDLE while calib_done is 0 or neither req is high.
  - One req high: grant it.
  - Both req high: grant the requester that is not last_grant.
  - On grant: latch wren, addr and wdata; update last_grant.
  - Next state is WR_DATA if wren=1, otherwise RD_CMD.
- WR_DATA: if wr_full=0, pulse wr_en with wr_data set and go to WR_CMD; otherwise stay.
- WR_CMD: if cmd_full=0, pulse cmd_en with instr=0 and the address, then go to DONE; otherwise stay.
- RD_CMD: if cmd_full=0, pulse cmd_en with instr=1, clear the timeout counter and go to RD_WAIT; otherwise stay.
- RD_WAIT:
  - If rd_empty=0: pulse rd_en, capture rd_data into rdata, err=0, go to DONE.
  - Else if the counter equals RD_TIMEOUT: err=1, rdata unchanged, go to DONE.
  - Otherwise increment the counter.
- DONE:
  - ack of the granted requester is 1 for exactly one cycle; err is valid during that cycle.
  - Next state is IDLE.
  - The requester must drop req in the cycle after ack; a req still high in IDLE is a new request.
- Latency with no backpressure, counting clk cycles from the first IDLE cycle where req is seen until ack:
  - Write: 4 cycles.
  - Read: 4 cycles plus the cycles rd_empty stays high.
- Only one access is outstanding at any time; the other requester waits in IDLE arbitration.
- Requester changes to wren, addr or wdata after grant are ignored.
- err is 0 whenever no ack is asserted.

Test Plan:
- Write: calib_done=1, req0 with wren0=1, addr0=18'h00010, wdata0=32'hDEADBEEF -> wr_en with wr_data=DEADBEEF, then cmd_en with instr=0 and byte_addr=30'h40, ack0 4 cycles after req; ack1 stays 0.
- Read: req1 with wren1=0, addr1=18'h3FFFF; rd_empty drops 3 cycles after cmd_en with rd_data=32'h12345678 -> rd_en for one cycle, rdata=12345678, ack1 pulse, err=0.
- Contention: req0 and req1 both held for 4 back-to-back accesses -> grants alternate 0,1,0,1, starting with 0 after reset.
- Backpressure: wr_full=1 for 5 cycles, then cmd_full=1 for 3 cycles -> exactly one wr_en and one cmd_en pulse, ack 8 cycles later than nominal.
- Timeout and calibration: rd_empty stuck at 1 -> ack with err=1 after RD_TIMEOUT cycles in RD_WAIT, rdata unchanged. calib_done=0 with req0 high -> no cmd_en and no ack.
- Reset: rst_n low during RD_WAIT -> the next cycle is IDLE with all strobes 0 and no ack.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// Two-requester round-robin arbiter for a single-word LPDDR user port.
// Each granted access becomes one BL1 command; read data and a one-cycle ack return to the winner.
module ddr_port_arbiter #(
  parameter int unsigned RD_TIMEOUT = 255,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic              req0,
  input  logic              req1,
  input  logic              wren0,
  input  logic              wren1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [29:0]       cmd_byte_addr,
  input  logic              cmd_full,
  output logic              wr_en,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_mask,
  input  logic              wr_full,
  output logic              rd_en,
  input  logic [31:0]       rd_data,
  input  logic              rd_empty
);

  localparam int CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_CMD  = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pick_s;

  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                cmd_en_q, cmd_en_d;
  logic [2:0]          cmd_instr_q, cmd_instr_d;
  logic [29:0]         cmd_addr_q, cmd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                rd_en_q, rd_en_d;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    if (req0 && req1) begin
      pick_s = ~last_grant_q;
    end else begin
      pick_s = req1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wren_d       = wren_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    cmd_instr_d  = cmd_instr_q;
    cmd_addr_d   = cmd_addr_q;
    wr_data_d    = wr_data_q;
    cmd_en_d     = 1'b0;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    err_d        = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (calib_done && (req0 || req1)) begin
          gnt_d        = pick_s;
          last_grant_d = pick_s;
          wren_d       = pick_s ? wren1 : wren0;
          addr_d       = pick_s ? addr1 : addr0;
          wdata_d      = pick_s ? wdata1 : wdata0;
          if (pick_s ? wren1 : wren0) begin
            state_d = S_WR_DATA;
          end else begin
            state_d = S_RD_CMD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (!wr_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = wdata_q;
          state_d   = S_WR_CMD;
        end else begin
          state_d = S_WR_DATA;
        end
      end
      S_WR_CMD: begin
        if (!cmd_full) begin
          cmd_en_d    = 1'b1;
          cmd_instr_d = 3'd0;
          cmd_addr_d  = 30'({addr_q, 2'b00});
          state_d     = S_DONE;
        end else begin
          state_d = S_WR_CMD;
        end
      end
      S_RD_CMD: begin
        if (!cmd_full) begin
          cmd_en_d    = 1'b1;
          cmd_instr_d = 3'd1;
          cmd_addr_d  = 30'({addr_q, 2'b00});
          cnt_d       = '0;
          state_d     = S_RD_WAIT;
        end else begin
          state_d = S_RD_CMD;
        end
      end
      S_RD_WAIT: begin
        if (!rd_empty) begin
          rd_en_d = 1'b1;
          rdata_d = rd_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ack is registered on entry so it is high exactly during the DONE cycle.
    if (state_d == S_DONE) begin
      ack0_d = ~gnt_q;
      ack1_d = gnt_q;
    end else begin
      ack0_d = 1'b0;
      ack1_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'd0;
      busy_q       <= 1'b0;
      cmd_en_q     <= 1'b0;
      cmd_instr_q  <= 3'd0;
      cmd_addr_q   <= 30'd0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 32'd0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      cmd_en_q     <= cmd_en_d;
      cmd_instr_q  <= cmd_instr_d;
      cmd_addr_q   <= cmd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign cmd_en        = cmd_en_q;
  assign cmd_instr     = cmd_instr_q;
  assign cmd_bl        = 6'd0;
  assign cmd_byte_addr = cmd_addr_q;
  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign wr_mask       = 4'd0;
  assign rd_en         = rd_en_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter; the bench plays both requesters and the controller port.
module tb_ddr_port_arbiter;
  localparam int RD_TIMEOUT = 255;
  localparam int ADDR_W     = 18;

  logic clk = 1'b0;
  logic rst_n, calib_done, req0, req1, wren0, wren1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0] wdata0, wdata1, rdata, wr_data, rd_data;
  logic ack0, ack1, err, busy, cmd_en, cmd_full, wr_en, wr_full, rd_en, rd_empty;
  logic [2:0] cmd_instr;
  logic [5:0] cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic [3:0] wr_mask;

  ddr_port_arbiter #(.RD_TIMEOUT(RD_TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .req0(req0), .req1(req1), .wren0(wren0), .wren1(wren1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_wr, n_cmd, n_rd, n;
  logic [2:0]  last_instr;
  logic [29:0] last_addr;
  logic [31:0] last_wdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts port strobes each cycle until an ack appears; releases backpressure at given cycles.
  task automatic wait_ack(input int limit, input int wr_rel, input int cmd_rel, input int rd_rel,
                          output int cyc);
    n_wr = 0; n_cmd = 0; n_rd = 0; cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (wr_en) begin n_wr++; last_wdata = wr_data; end
      if (cmd_en) begin n_cmd++; last_instr = cmd_instr; last_addr = cmd_byte_addr; end
      if (rd_en) n_rd++;
      if (ack0 || ack1) begin cyc = i; break; end
      if (i == wr_rel) wr_full = 1'b0;
      if (i == cmd_rel) cmd_full = 1'b0;
      if (i == rd_rel) rd_empty = 1'b0;
    end
    check_val("ack_seen", {31'd0, ack0 | ack1}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (err) check_val("err_only_with_ack", {31'd0, ack0 | ack1}, 32'd1);
  end

  initial begin
    calib_done = 1'b1; req0 = 1'b0; req1 = 1'b0; wren0 = 1'b0; wren1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = 32'd0; wdata1 = 32'd0;
    cmd_full = 1'b0; wr_full = 1'b0; rd_empty = 1'b1; rd_data = 32'd0;
    do_reset();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_strobes", {26'd0, ack0, ack1, err, cmd_en, wr_en, rd_en}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);

    // Write: req seen in cycle 0, wr_en in cycle 2, cmd_en and ack0 in cycle 3.
    req0 = 1'b1; wren0 = 1'b1; addr0 = 18'h00010; wdata0 = 32'hDEADBEEF;
    tick();
    wdata0 = 32'h0; addr0 = 18'h00003;
    wait_ack(10, 0, 0, 0, n);
    check_val("wr_lat", n, 32'd2);
    check_val("wr_en_cnt", n_wr, 32'd1);
    check_val("wr_data", last_wdata, 32'hDEADBEEF);
    check_val("wr_cmd_cnt", n_cmd, 32'd1);
    check_val("wr_instr", {29'd0, last_instr}, 32'd0);
    check_val("wr_addr", {2'd0, last_addr}, 32'h40);
    check_val("wr_acks", {30'd0, ack0, ack1}, 32'd2);
    check_val("wr_const", {22'd0, cmd_bl, wr_mask}, 32'd0);
    req0 = 1'b0;
    tick();
    check_val("wr_after", {30'd0, ack0, busy}, 32'd0);

    // Read: rd_empty drops three cycles after cmd_en.
    req1 = 1'b1; wren1 = 1'b0; addr1 = 18'h3FFFF; rd_data = 32'h12345678;
    wait_ack(20, 0, 0, 5, n);
    check_val("rd_lat", n, 32'd6);
    check_val("rd_instr", {29'd0, last_instr}, 32'd1);
    check_val("rd_addr", {2'd0, last_addr}, 32'h000FFFFC);
    check_val("rd_en_cnt", n_rd, 32'd1);
    check_val("rd_rdata", rdata, 32'h12345678);
    check_val("rd_ack_err", {29'd0, ack0, ack1, err}, 32'd2);
    req1 = 1'b0; rd_empty = 1'b1;
    tick();
    check_val("rd_hold", rdata, 32'h12345678);
    check_val("rd_after", {29'd0, ack1, rd_en, err}, 32'd0);

    // Timeout: no data ever; ack after RD_TIMEOUT+1 cycles in RD_WAIT.
    req0 = 1'b1; wren0 = 1'b0; addr0 = 18'h00042;
    wait_ack(400, 0, 0, 0, n);
    check_val("to_lat", n, RD_TIMEOUT + 3);
    check_val("to_err_ack", {30'd0, ack0, err}, 32'd3);
    check_val("to_rd_en", n_rd, 32'd0);
    check_val("to_rdata", rdata, 32'h12345678);
    req0 = 1'b0;
    tick();
    check_val("to_err_clr", {31'd0, err}, 32'd0);

    // Contention after reset: grants alternate starting with requester 0.
    do_reset();
    wren0 = 1'b1; wren1 = 1'b1; addr0 = 18'h00100; addr1 = 18'h00200;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(12, 0, 0, 0, n);
      check_val("rr_lat", n, (k == 0) ? 32'd3 : 32'd4);
      check_val("rr_winner", {30'd0, ack0, ack1}, (k % 2 == 0) ? 32'd2 : 32'd1);
      check_val("rr_addr", {2'd0, last_addr}, (k % 2 == 0) ? 32'h400 : 32'h800);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    check_val("rr_idle", {29'd0, busy, ack0, ack1}, 32'd0);

    // Backpressure: 5 stalled WR_DATA cycles then 3 stalled WR_CMD cycles.
    wr_full = 1'b1; cmd_full = 1'b1;
    req0 = 1'b1; addr0 = 18'h00123; wdata0 = 32'hA5A50001;
    wait_ack(30, 6, 10, 0, n);
    check_val("bp_lat", n, 32'd11);
    check_val("bp_wr_cnt", n_wr, 32'd1);
    check_val("bp_cmd_cnt", n_cmd, 32'd1);
    check_val("bp_wdata", last_wdata, 32'hA5A50001);
    req0 = 1'b0;
    tick();

    // Calibration low blocks the grant; once high the read completes.
    calib_done = 1'b0; req0 = 1'b1; wren0 = 1'b0; addr0 = 18'h00005;
    rd_empty = 1'b0; rd_data = 32'hCAFEF00D;
    n_cmd = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_en) n_cmd++;
      if (ack0 || ack1 || busy) n++;
    end
    check_val("cal_no_cmd", n_cmd, 32'd0);
    check_val("cal_no_act", n, 32'd0);
    calib_done = 1'b1;
    wait_ack(10, 0, 0, 0, n);
    check_val("cal_lat", n, 32'd3);
    check_val("cal_rdata", rdata, 32'hCAFEF00D);
    req0 = 1'b0; rd_empty = 1'b1;
    tick();

    // Reset during RD_WAIT abandons the access.
    req1 = 1'b1; wren1 = 1'b0; addr1 = 18'h00077;
    for (int i = 0; i < 4; i++) tick();
    check_val("rst_mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check_val("rst_mid_strobes", {25'd0, busy, ack0, ack1, err, cmd_en, wr_en, rd_en}, 32'd0);
    check_val("rst_mid_rdata", rdata, 32'd0);
    rst_n = 1'b1; req1 = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack0 || ack1) n++;
    end
    check_val("rst_mid_no_ack", n, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
